// File: rtl/adder_rr_arbiter_pkg.sv
// Shared constants and the operand record for the round-robin shared-adder block.
package adder_pkg;
  localparam int DATA_W   = 32;
  localparam int SUM_W    = DATA_W + 1;
  localparam int ID_MAX_W = 4;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic [ID_MAX_W-1:0]      id;
  } operand_t;
endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request and response bundle between the requesters/consumer and the shared adder.
interface adder_rr_arbiter_if
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [DATA_W*N_REQ-1:0] req_a;
  logic [DATA_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [SUM_W-1:0]        rsp_sum;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/adder_rr_arbiter_rr_picker.sv
// Round-robin picker: first set request after i_ptr, wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);
  logic [ID_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    // The pointer itself is visited last, so the previous winner has lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/ripple_carry_adder.sv
// 32-bit ripple-carry adder; bit 32 of the result is the raw carry-out.
module ripple_carry_adder
  import adder_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic [SUM_W-1:0]         o_sum
);
  logic [DATA_W:0] w_c;

  always_comb begin
    w_c   = '0;
    o_sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_sum[DATA_W] = w_c[DATA_W];
  end
endmodule

// File: rtl/adder_rr_arbiter.sv
// One shared adder behind a round-robin arbiter: operand stage p1, result stage p2,
// tagged responses with downstream backpressure.
module adder_rr_arbiter
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  adder_rr_arbiter_if.slave bus
);
  logic signed [DATA_W-1:0] w_a_arr [N_REQ];
  logic signed [DATA_W-1:0] w_b_arr [N_REQ];
  logic [N_REQ-1:0]         w_gnt;
  logic [ID_W-1:0]          w_idx;
  logic                     w_any;
  logic                     w_s2_load;
  logic                     w_s1_en;
  logic [ID_W-1:0]          r_ptr;

  operand_t                 r_op_p1;
  logic                     r_vld_p1;
  logic [SUM_W-1:0]         w_sum_p1;

  logic [SUM_W-1:0]         r_sum_p2;
  logic [ID_W-1:0]          r_id_p2;
  logic                     r_vld_p2;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
    assign w_b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_s2_load = r_vld_p1 && (!r_vld_p2 || bus.rsp_ready);
  assign w_s1_en   = !r_vld_p1 || w_s2_load;

  assign bus.req_ready = w_gnt & {N_REQ{w_s1_en & ~rst}};

  // Stage p1: operand register, filled from the granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_ptr    <= ID_W'(N_REQ - 1);
    end else if (w_s1_en) begin
      r_vld_p1 <= w_any;
      if (w_any) begin
        r_ptr <= w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_en && w_any) begin
      r_op_p1.a  <= w_a_arr[w_idx];
      r_op_p1.b  <= w_b_arr[w_idx];
      r_op_p1.id <= ID_MAX_W'(w_idx);
    end
  end

  ripple_carry_adder u_adder (
    .i_a   (r_op_p1.a),
    .i_b   (r_op_p1.b),
    .o_sum (w_sum_p1)
  );

  // Stage p2: result register driving the response channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_sum_p2 <= '0;
      r_id_p2  <= '0;
    end else if (w_s2_load) begin
      r_vld_p2 <= 1'b1;
      r_sum_p2 <= w_sum_p1;
      r_id_p2  <= ID_W'(r_op_p1.id);
    end else if (bus.rsp_ready) begin
      r_vld_p2 <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_vld_p2;
  assign bus.rsp_sum   = r_sum_p2;
  assign bus.rsp_id    = r_id_p2;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: reset, latency, round-robin order, carry vectors,
// backpressure and reset while both pipeline stages hold data.
module tb_adder_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_rr_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();
  adder_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] va [4] = '{default: 32'd0};
  logic [31:0] vb [4] = '{default: 32'd0};
  assign bus.req_a = {va[3], va[2], va[1], va[0]};
  assign bus.req_b = {vb[3], vb[2], vb[1], vb[0]};

  logic [31:0] tab_a [4][4];
  logic [31:0] tab_b [4][4];
  int          quota [4];
  int          cnt   [4];
  logic [3:0]  acc = '0;

  logic [3:0]  mon_pend  = '0;
  logic        mon_armed = 1'b0;

  // A requester must keep req_valid high until its transfer happens.
  always begin
    @(negedge clk);
    #4;
    if (mon_armed && !rst) begin
      for (int m = 0; m < N_REQ; m++) begin
        if (mon_pend[2'(m)] && !bus.req_valid[2'(m)]) begin
          errors++;
          $display("FAIL protocol: req_valid[%0d] dropped before accept", m);
        end
      end
    end
    mon_pend  = bus.req_valid & ~bus.req_ready;
    mon_armed = !rst;
  end

  task automatic set_tab(input int i, input int n, input logic [31:0] a, input logic [31:0] b);
    tab_a[2'(i)][2'(n)] = a;
    tab_b[2'(i)][2'(n)] = b;
  endtask

  task automatic start_stream;
    for (int i = 0; i < N_REQ; i++) begin
      cnt[2'(i)]           = 0;
      bus.req_valid[2'(i)] = (quota[2'(i)] > 0);
      va[2'(i)]            = tab_a[2'(i)][0];
      vb[2'(i)]            = tab_b[2'(i)][0];
    end
    acc = '0;
  endtask

  task automatic apply_acc;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[2'(i)]) begin
        cnt[2'(i)]++;
        if (cnt[2'(i)] >= quota[2'(i)]) bus.req_valid[2'(i)] = 1'b0;
        else begin
          va[2'(i)] = tab_a[2'(i)][2'(cnt[2'(i)])];
          vb[2'(i)] = tab_b[2'(i)][2'(cnt[2'(i)])];
        end
      end
    end
    acc = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_sum !== 33'd0) begin errors++; $display("FAIL reset_rsp_sum got=%h exp=0", bus.rsp_sum); end
    checks++;
    if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    va[0] = 32'd5; vb[0] = 32'd7;
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", bus.rsp_valid); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 33'd12 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp got v=%b sum=%h id=%0d exp v=1 sum=00000000c id=0", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin;
    int          exp_g [6];
    logic [32:0] exp_s [6];
    exp_g = '{0, 1, 2, 3, 0, 1};
    exp_s = '{33'h0_0000000B, 33'h0_00000016, 33'h0_FFFFFFFE, 33'h0_00000BB8, 33'h0_23456789, 33'h1_00000001};
    quota = '{2, 2, 1, 1};
    set_tab(0, 0, 32'd10, 32'd1);          set_tab(0, 1, 32'h12345678, 32'h11111111);
    set_tab(1, 0, 32'd20, 32'd2);          set_tab(1, 1, 32'hFFFFFFFF, 32'd2);
    set_tab(2, 0, 32'hFFFFFFFB, 32'd3);    set_tab(3, 0, 32'd1000, 32'd2000);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) start_stream(); else apply_acc();
      #1;
      checks++;
      if (c < 6) begin
        if (bus.req_ready !== 4'(1 << exp_g[c])) begin
          errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << exp_g[c]));
        end
      end else if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_grant_idle c=%0d got=%b exp=0000", c, bus.req_ready);
      end
      checks++;
      if (c >= 2 && c < 8) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_g[c-2]) || bus.rsp_sum !== exp_s[c-2]) begin
          errors++;
          $display("FAIL rr_rsp c=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_g[c-2], exp_s[c-2]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rr_rsp_idle c=%0d got=%b exp=0", c, bus.rsp_valid);
      end
      acc = bus.req_valid & bus.req_ready;
    end
  endtask

  task automatic test_sparse;
    int          exp_g [4];
    logic [32:0] exp_s [4];
    exp_g = '{3, 1, 3, 1};
    exp_s = '{33'h0_0000000F, 33'h0_00000300, 33'h1_00000000, 33'h0_FFFFFFFE};
    quota = '{0, 2, 0, 2};
    set_tab(1, 0, 32'h100, 32'h200);       set_tab(1, 1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    set_tab(3, 0, 32'd7, 32'd8);           set_tab(3, 1, 32'hFFFFFFF0, 32'h10);
    set_tab(0, 0, 32'd0, 32'd0);           set_tab(2, 0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) start_stream(); else apply_acc();
      #1;
      checks++;
      if (c < 4) begin
        if (bus.req_ready !== 4'(1 << exp_g[c])) begin
          errors++; $display("FAIL sparse_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << exp_g[c]));
        end
      end else if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL sparse_grant_idle c=%0d got=%b exp=0000", c, bus.req_ready);
      end
      checks++;
      if (c >= 2 && c < 6) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_g[c-2]) || bus.rsp_sum !== exp_s[c-2]) begin
          errors++;
          $display("FAIL sparse_rsp c=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_g[c-2], exp_s[c-2]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL sparse_rsp_idle c=%0d got=%b exp=0", c, bus.rsp_valid);
      end
      acc = bus.req_valid & bus.req_ready;
    end
  endtask

  task automatic test_carry;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [32:0] ts [3];
    ta = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    tb = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    ts = '{33'h0_80000000, 33'h1_FFFFFFFE, 33'h1_00000000};
    bus.rsp_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      va[2'(v)] = ta[v];
      vb[2'(v)] = tb[v];
      bus.req_valid = 4'(1 << v);
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << v)) begin
        errors++; $display("FAIL carry_ready v=%0d got=%b exp=%b", v, bus.req_ready, 4'(1 << v));
      end
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== ts[v] || bus.rsp_id !== 2'(v)) begin
        errors++;
        $display("FAIL carry_sum v=%0d got v=%b sum=%h id=%0d exp v=1 sum=%h id=%0d",
                 v, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, ts[v], v);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [10:0] exp_rdy;
    int          exp_slot [11];
    logic [32:0] exp_s [4];
    exp_rdy  = 11'b000_1100_0011;
    exp_slot = '{-1, -1, 0, 0, 0, 0, 0, 1, 2, 3, -1};
    exp_s    = '{33'h0_00000002, 33'h1_00000000, 33'h0_FFFFFFFF, 33'h1_00000063};
    quota    = '{0, 0, 4, 0};
    set_tab(2, 0, 32'd1, 32'd1);           set_tab(2, 1, 32'hFFFFFFFF, 32'd1);
    set_tab(2, 2, 32'h80000000, 32'h7FFFFFFF); set_tab(2, 3, 32'd100, 32'hFFFFFFFF);
    set_tab(0, 0, 32'd0, 32'd0); set_tab(1, 0, 32'd0, 32'd0); set_tab(3, 0, 32'd0, 32'd0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) start_stream(); else apply_acc();
      bus.rsp_ready = (c >= 6);
      #1;
      checks++;
      if (bus.req_ready !== (exp_rdy[c] ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL bp_ready c=%0d got=%b exp_bit=%b", c, bus.req_ready, exp_rdy[c]);
      end
      checks++;
      if (exp_slot[c] >= 0) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_sum !== exp_s[exp_slot[c]]) begin
          errors++;
          $display("FAIL bp_rsp c=%0d got v=%b id=%0d sum=%h exp v=1 id=2 sum=%h",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_s[exp_slot[c]]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_rsp_idle c=%0d got=%b exp=0", c, bus.rsp_valid);
      end
      if (c == 5) begin
        checks++;
        if (cnt[2] !== 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", cnt[2]); end
      end
      acc = bus.req_valid & bus.req_ready;
    end
  endtask

  task automatic test_reset_midflight;
    quota = '{0, 3, 0, 0};
    set_tab(1, 0, 32'd9, 32'd9); set_tab(1, 1, 32'd9, 32'd9); set_tab(1, 2, 32'd9, 32'd9);
    set_tab(0, 0, 32'd0, 32'd0); set_tab(2, 0, 32'd0, 32'd0); set_tab(3, 0, 32'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) start_stream(); else apply_acc();
      bus.rsp_ready = 1'b0;
      #1;
      acc = bus.req_valid & bus.req_ready;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_full got v=%b rdy=%b exp v=1 rdy=0000", bus.rsp_valid, bus.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    va[0] = 32'd40; vb[0] = 32'd2;
    va[2] = 32'd3;  vb[2] = 32'd4;
    va[3] = 32'd5;  vb[3] = 32'd6;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 33'd0 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_cleared got v=%b sum=%h id=%0d exp v=0 sum=0 id=0", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got=%b exp=0", bus.rsp_valid); end
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_second_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 33'd42) begin
      errors++;
      $display("FAIL midrst_rsp got v=%b id=%0d sum=%h exp v=1 id=0 sum=00000002a", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    do_reset();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_sparse();
    test_carry();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
